packet_readout_serializer: RTL and testbench

//  Downstream of the cluster packet builder. Buffers finished 51-bit packets
//  ({L0/BC ID[50:35], HIT0..3[34:3], NO01[2], OVERFLOW[1], NOT_EMPTY[0]}) in a

---
 rtl/packet_readout_serializer.sv | 154 +++++++++++++++
 tb/tb_packet_readout_serializer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_readout_serializer.sv
// Packet readout serializer: a small packet FIFO feeding a framed MSB-first serial line.
// Each frame is a start bit followed by PCKT_W data bits; writes that find the FIFO full are counted as drops.
module packet_readout_serializer #(
  parameter int PCKT_W = 51,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PCKT_W-1:0] PCKT_I,
  input  logic              PCKT_WR,
  input  logic              SKIP_EMPTY,
  input  logic              SER_EN,
  output logic              DATA_O,
  output logic              DATA_VALID,
  output logic              BUSY,
  output logic              FIFO_EMPTY,
  output logic              FIFO_FULL,
  output logic [AW:0]       OCC,
  output logic [7:0]        DROP_CNT
);

  localparam int CW = $clog2(PCKT_W);
  localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   OCC_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   OCC_DEPTH = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PCKT_W - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t            state_r;
  logic [PCKT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [PCKT_W-1:0] sreg_r;
  logic [CW-1:0]     bit_cnt_r;
  logic              wr_req_s;
  logic              pop_s;
  logic              wr_acc_s;
  logic              drop_s;
  logic [AW:0]       occ_nxt_s;

  // Write qualification, pop decision and next occupancy.
  always_comb begin
    wr_req_s  = PCKT_WR & ~(SKIP_EMPTY & ~PCKT_I[0]);
    pop_s     = (state_r == IDLE) & SER_EN & ~FIFO_EMPTY;
    // A pop on the same edge frees the slot, so a full FIFO can still take the write.
    wr_acc_s  = wr_req_s & (~FIFO_FULL | pop_s);
    drop_s    = wr_req_s & FIFO_FULL & ~pop_s;
    occ_nxt_s = OCC;
    if (wr_acc_s && !pop_s) begin
      occ_nxt_s = OCC + OCC_ONE;
    end else if (pop_s && !wr_acc_s) begin
      occ_nxt_s = OCC - OCC_ONE;
    end else begin
      occ_nxt_s = OCC;
    end
  end

  // Packet storage; pointers carry the reset, the array itself does not.
  always_ff @(posedge CLK) begin
    if (wr_acc_s) begin
      mem_r[wptr_r] <= PCKT_I;
    end
  end

  // FIFO pointers, occupancy flags and saturating drop counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      OCC        <= OCC_ZERO;
      FIFO_EMPTY <= 1'b1;
      FIFO_FULL  <= 1'b0;
      DROP_CNT   <= 8'd0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      OCC        <= occ_nxt_s;
      FIFO_EMPTY <= (occ_nxt_s == OCC_ZERO);
      FIFO_FULL  <= (occ_nxt_s == OCC_DEPTH);
      if (drop_s && (DROP_CNT != 8'hFF)) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end
    end
  end

  // Serial framing FSM; outputs are loaded with the values of the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      sreg_r     <= '0;
      bit_cnt_r  <= '0;
      DATA_O     <= 1'b0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r    <= START;
            sreg_r     <= mem_r[rptr_r];
            bit_cnt_r  <= CNT_LAST;
            DATA_O     <= 1'b1;
            DATA_VALID <= 1'b1;
            BUSY       <= 1'b1;
          end else begin
            DATA_O     <= 1'b0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
          end
        end
        START: begin
          state_r    <= SHIFT;
          DATA_O     <= sreg_r[PCKT_W-1];
          sreg_r     <= {sreg_r[PCKT_W-2:0], 1'b0};
          DATA_VALID <= 1'b1;
          BUSY       <= 1'b1;
        end
        SHIFT: begin
          // bit_cnt_r is the index of the packet bit currently on DATA_O.
          if (bit_cnt_r == '0) begin
            state_r    <= GAP;
            DATA_O     <= 1'b0;
            DATA_VALID <= 1'b0;
          end else begin
            DATA_O     <= sreg_r[PCKT_W-1];
            sreg_r     <= {sreg_r[PCKT_W-2:0], 1'b0};
            bit_cnt_r  <= bit_cnt_r - CW'(1);
            DATA_VALID <= 1'b1;
          end
          BUSY <= 1'b1;
        end
        GAP: begin
          state_r    <= IDLE;
          DATA_O     <= 1'b0;
          DATA_VALID <= 1'b0;
          BUSY       <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          DATA_O     <= 1'b0;
          DATA_VALID <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_readout_serializer.sv
// Bench for packet_readout_serializer: scoreboard of written packets compared against
// frames decoded from the serial line, plus occupancy/drop/reset scenarios.
module tb_packet_readout_serializer;

  localparam int W = 51;
  localparam logic [W-1:0] PAT = 51'h7A5A53C3CF0F1;

  logic         CLK;
  logic         RST;
  logic [W-1:0] PCKT_I;
  logic         PCKT_WR;
  logic         SKIP_EMPTY;
  logic         SER_EN;
  logic         DATA_O;
  logic         DATA_VALID;
  logic         BUSY;
  logic         FIFO_EMPTY;
  logic         FIFO_FULL;
  logic [2:0]   OCC;
  logic [7:0]   DROP_CNT;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  packet_readout_serializer #(.PCKT_W(W), .DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .RST(RST), .PCKT_I(PCKT_I), .PCKT_WR(PCKT_WR),
    .SKIP_EMPTY(SKIP_EMPTY), .SER_EN(SER_EN), .DATA_O(DATA_O),
    .DATA_VALID(DATA_VALID), .BUSY(BUSY), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_FULL(FIFO_FULL), .OCC(OCC), .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_pkt();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return {t[W-1:1], 1'b1};
  endfunction

  task automatic wr(input logic [W-1:0] p);
    PCKT_I  = p;
    PCKT_WR = 1'b1;
    tick();
    PCKT_WR = 1'b0;
  endtask

  // Wait (bounded) for a frame, decode it; returns in the cycle after the last data bit.
  task automatic receive_frame(input string name, output logic [W-1:0] p);
    int n;
    bit bad_len;
    n = 0;
    p = '0;
    bad_len = 1'b0;
    while (DATA_VALID !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (DATA_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: DATA_VALID=%b after %0d cycles, required 1", name, DATA_VALID, n);
      return;
    end
    checks++;
    if (DATA_O !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_bit: got %b, required 1", name, DATA_O);
    end
    for (int i = W - 1; i >= 0; i--) begin
      tick();
      if (DATA_VALID !== 1'b1) bad_len = 1'b1;
      p[i] = DATA_O;
    end
    tick();
    if (DATA_VALID !== 1'b0) bad_len = 1'b1;
    checks++;
    if (bad_len) begin
      errors++;
      $display("FAIL %s_valid_len: DATA_VALID not high for exactly 52 cycles (now %b)", name, DATA_VALID);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; PCKT_I = '0; PCKT_WR = 1'b0; SKIP_EMPTY = 1'b0; SER_EN = 1'b0;
    repeat (2) tick();
    checks++;
    if ({DATA_O, DATA_VALID, BUSY, FIFO_EMPTY, FIFO_FULL} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00010", {DATA_O, DATA_VALID, BUSY, FIFO_EMPTY, FIFO_FULL});
    end
    checks++;
    if (OCC !== 3'd0 || DROP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: OCC=%0d DROP_CNT=%0d, required 0 0", OCC, DROP_CNT);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    logic [W-1:0] got, exp;
    SER_EN = 1'b1;
    sb.push_back(PAT);
    wr(PAT);
    checks++;
    if (OCC !== 3'd1 || DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_after_write: OCC=%0d DATA_VALID=%b, required 1 0", OCC, DATA_VALID);
    end
    tick();
    checks++;
    if (DATA_VALID !== 1'b1 || DATA_O !== 1'b1 || OCC !== 3'd0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: VALID=%b DATA=%b OCC=%0d BUSY=%b, required 1 1 0 1", DATA_VALID, DATA_O, OCC, BUSY);
    end
    receive_frame("single", got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL single_data: got %h, required %h", got, exp);
    end
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_gap: BUSY=%b, required 1", BUSY);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: BUSY=%b, required 0", BUSY);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] p, got, exp;
    SER_EN = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      p = rnd_pkt();
      if (i < 4) sb.push_back(p);
      wr(p);
    end
    checks++;
    if (OCC !== 3'd4 || FIFO_FULL !== 1'b1 || FIFO_EMPTY !== 1'b0 || DROP_CNT !== 8'd2) begin
      errors++;
      $display("FAIL overflow_state: OCC=%0d FULL=%b EMPTY=%b DROP=%0d, required 4 1 0 2", OCC, FIFO_FULL, FIFO_EMPTY, DROP_CNT);
    end
    SER_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      receive_frame("overflow", got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow_data%0d: got %h, required %h", i, got, exp);
      end
    end
    tick();
    checks++;
    if (FIFO_EMPTY !== 1'b1 || OCC !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drained: EMPTY=%b OCC=%0d, required 1 0", FIFO_EMPTY, OCC);
    end
    SER_EN = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [W-1:0] p, got, exp;
    SER_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = rnd_pkt();
      sb.push_back(p);
      wr(p);
    end
    p = rnd_pkt();
    sb.push_back(p);
    PCKT_I = p; PCKT_WR = 1'b1; SER_EN = 1'b1;
    tick();
    PCKT_WR = 1'b0; SER_EN = 1'b0;
    checks++;
    if (OCC !== 3'd4 || FIFO_FULL !== 1'b1 || DROP_CNT !== 8'd2 || DATA_VALID !== 1'b1) begin
      errors++;
      $display("FAIL simul_state: OCC=%0d FULL=%b DROP=%0d VALID=%b, required 4 1 2 1", OCC, FIFO_FULL, DROP_CNT, DATA_VALID);
    end
    receive_frame("simul_first", got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL simul_first_data: got %h, required %h", got, exp);
    end
    repeat (5) tick();
    checks++;
    if (BUSY !== 1'b0 || OCC !== 3'd4) begin
      errors++;
      $display("FAIL ser_en_hold: BUSY=%b OCC=%0d, required 0 4", BUSY, OCC);
    end
    SER_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      receive_frame("simul", got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simul_data%0d: got %h, required %h", i, got, exp);
      end
    end
    SER_EN = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_skip_empty();
    logic [W-1:0] p, got, exp;
    SER_EN = 1'b0;
    SKIP_EMPTY = 1'b1;
    p = {rnd_pkt()} & ~{{(W-1){1'b0}}, 1'b1};
    wr(p);
    checks++;
    if (OCC !== 3'd0 || FIFO_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL skip_ignored: OCC=%0d EMPTY=%b, required 0 1", OCC, FIFO_EMPTY);
    end
    SKIP_EMPTY = 1'b0;
    sb.push_back(p);
    wr(p);
    checks++;
    if (OCC !== 3'd1) begin
      errors++;
      $display("FAIL skip_off_write: OCC=%0d, required 1", OCC);
    end
    SKIP_EMPTY = 1'b1;
    p = rnd_pkt();
    sb.push_back(p);
    wr(p);
    checks++;
    if (OCC !== 3'd2) begin
      errors++;
      $display("FAIL skip_hit_write: OCC=%0d, required 2", OCC);
    end
    SKIP_EMPTY = 1'b0;
    SER_EN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      receive_frame("skip", got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL skip_data%0d: got %h, required %h", i, got, exp);
      end
    end
    SER_EN = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_saturation_wrap();
    logic [W-1:0] p, got, exp;
    SER_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = rnd_pkt();
      sb.push_back(p);
      wr(p);
    end
    for (int i = 0; i < 300; i++) begin
      wr(rnd_pkt());
      if (i == 251) begin
        checks++;
        if (DROP_CNT !== 8'd254) begin
          errors++;
          $display("FAIL drop_254: got %0d, required 254", DROP_CNT);
        end
      end
    end
    checks++;
    if (DROP_CNT !== 8'd255 || OCC !== 3'd4) begin
      errors++;
      $display("FAIL drop_saturate: DROP=%0d OCC=%0d, required 255 4", DROP_CNT, OCC);
    end
    SER_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      receive_frame("sat", got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sat_data%0d: got %h, required %h", i, got, exp);
      end
    end
    for (int i = 0; i < 10; i++) begin
      p = rnd_pkt();
      sb.push_back(p);
      wr(p);
      receive_frame("wrap", got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_data%0d: got %h, required %h", i, got, exp);
      end
    end
    tick();
    checks++;
    if (OCC !== 3'd0 || DROP_CNT !== 8'd255) begin
      errors++;
      $display("FAIL wrap_end: OCC=%0d DROP=%0d, required 0 255", OCC, DROP_CNT);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    SER_EN = 1'b1;
    wr(rnd_pkt());
    wr(rnd_pkt());
    n = 0;
    while (DATA_VALID !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    repeat (10) tick();
    checks++;
    if (DATA_VALID !== 1'b1 || OCC !== 3'd1) begin
      errors++;
      $display("FAIL rst_pre_shift: VALID=%b OCC=%0d, required 1 1", DATA_VALID, OCC);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (DATA_O !== 1'b0 || DATA_VALID !== 1'b0 || BUSY !== 1'b0 || OCC !== 3'd0 || DROP_CNT !== 8'd0 || FIFO_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: DATA=%b VALID=%b BUSY=%b OCC=%0d DROP=%0d EMPTY=%b, required 0 0 0 0 0 1",
               DATA_O, DATA_VALID, BUSY, OCC, DROP_CNT, FIFO_EMPTY);
    end
    sb.delete();
    tick();
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (DATA_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: VALID=%b BUSY=%b, required 0 0", DATA_VALID, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_full_simultaneous();
    test_skip_empty();
    test_saturation_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
